// File: rtl/instruction_fetcher_pkg.sv
// Shared word/instruction types and instruction-cache geometry for the fetch front end.
package instruction_fetcher_pkg;

  localparam int WORD_WIDTH = 32;

  // Range types for machine words and instruction encodings.
  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [31:0]           instruction_t;

  localparam word_t ZERO_WORD = '0;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  // Cache geometry for the default configuration: 32 one-word entries.
  localparam int ICACHE_INDEX_WIDTH_DEFAULT = 5;
  localparam int ICACHE_TAG_WIDTH_DEFAULT   = 30 - ICACHE_INDEX_WIDTH_DEFAULT;

  typedef logic [ICACHE_INDEX_WIDTH_DEFAULT-1:0] icache_index_t;
  typedef logic [ICACHE_TAG_WIDTH_DEFAULT-1:0]   icache_tag_t;

  function automatic word_t next_pc(word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetcher_if.sv
// Fetch unit boundary: ROB redirect, dispatch stall, memory-controller refill and decoder issue.
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic         stall_in;
  logic         rob_jump_in;
  word_t        rob_pc_in;
  logic         mc_req_out;
  word_t        mc_addr_out;
  logic         mc_ready_in;
  instruction_t mc_data_in;
  logic         dec_issue_signal_out;
  instruction_t dec_inst_out;
  word_t        dec_pc_out;

  modport master (
    input  stall_in, rob_jump_in, rob_pc_in, mc_ready_in, mc_data_in,
    output mc_req_out, mc_addr_out, dec_issue_signal_out, dec_inst_out, dec_pc_out
  );

  modport slave (
    output stall_in, rob_jump_in, rob_pc_in, mc_ready_in, mc_data_in,
    input  mc_req_out, mc_addr_out, dec_issue_signal_out, dec_inst_out, dec_pc_out
  );

endinterface

// File: rtl/instruction_fetcher_cache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
module instruction_cache
  import instruction_fetcher_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  word_t        lookup_addr,
  output logic         hit,
  output instruction_t hit_data,
  input  logic         fill_en,
  input  word_t        fill_addr,
  input  instruction_t fill_data
);

  localparam int ENTRIES   = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

  logic [ENTRIES-1:0]   valid;
  logic [TAG_WIDTH-1:0] tags [ENTRIES];
  instruction_t         data [ENTRIES];

  logic [INDEX_WIDTH-1:0] lookup_index, fill_index;
  logic [TAG_WIDTH-1:0]   lookup_tag, fill_tag;
  logic                   unused_offsets;

  assign lookup_index   = lookup_addr[INDEX_WIDTH+1:2];
  assign lookup_tag     = lookup_addr[31:INDEX_WIDTH+2];
  assign fill_index     = fill_addr[INDEX_WIDTH+1:2];
  assign fill_tag       = fill_addr[31:INDEX_WIDTH+2];
  assign unused_offsets = ^{lookup_addr[1:0], fill_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= TRUE;
    end
  end

  // NOTE: tag/data arrays are deliberately left unreset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index] <= fill_tag;
      data[fill_index] <= fill_data;
    end
  end

  assign hit      = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign hit_data = data[lookup_index];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch PC, IDLE/MISS refill FSM and registered decoder-issue outputs around the instruction cache.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int    ICACHE_INDEX_WIDTH = ICACHE_INDEX_WIDTH_DEFAULT,
  parameter word_t RESET_PC           = ZERO_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_fetcher_if.master bus
);

  typedef enum logic {FET_IDLE, FET_MISS} fet_state_t;

  fet_state_t   state;
  word_t        pc;
  word_t        miss_addr;
  logic         hit;
  instruction_t hit_data;
  logic         fill_en;

  // The fill is bound to miss_addr, so a redirect while waiting never corrupts it.
  assign fill_en = (state == FET_MISS) && bus.mc_ready_in;

  instruction_cache #(.INDEX_WIDTH(ICACHE_INDEX_WIDTH)) u_cache (
    .clk        (clk),
    .rst        (rst),
    .lookup_addr(pc),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (fill_en),
    .fill_addr  (miss_addr),
    .fill_data  (bus.mc_data_in)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                    <= FET_IDLE;
      pc                       <= RESET_PC;
      miss_addr                <= ZERO_WORD;
      bus.mc_req_out           <= FALSE;
      bus.mc_addr_out          <= ZERO_WORD;
      bus.dec_issue_signal_out <= FALSE;
      bus.dec_inst_out         <= ZERO_WORD;
      bus.dec_pc_out           <= ZERO_WORD;
    end else begin
      bus.dec_issue_signal_out <= FALSE;
      unique case (state)
        FET_IDLE: begin
          if (bus.rob_jump_in) begin
            pc <= bus.rob_pc_in;
          end else if (!bus.stall_in) begin
            if (hit) begin
              bus.dec_issue_signal_out <= TRUE;
              bus.dec_inst_out         <= hit_data;
              bus.dec_pc_out           <= pc;
              pc                       <= next_pc(pc);
            end else begin
              miss_addr       <= pc;
              bus.mc_req_out  <= TRUE;
              bus.mc_addr_out <= pc;
              state           <= FET_MISS;
            end
          end
        end
        FET_MISS: begin
          if (bus.rob_jump_in) begin
            pc <= bus.rob_pc_in;
          end
          if (bus.mc_ready_in) begin
            bus.mc_req_out <= FALSE;
            state          <= FET_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench: cycle stepper against an address-keyed cache model, directed and random scenarios.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_fetcher_if bus ();

  instruction_fetcher #(.ICACHE_INDEX_WIDTH(5), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the cache is a map from line index to the full word address held there.
  word_t        c_addr [int];
  instruction_t c_data [int];
  word_t        m_pc, m_miss_addr, m_addr, m_dpc;
  instruction_t m_inst;
  bit           m_miss, m_req, m_issue;
  int           m_miss_cycles;
  int           mc_latency = 3;
  bit           nop_mode = 1'b1;
  bit           prev_req_obs;
  int           req_rises;

  function automatic int idx_of(word_t a);
    return int'((a >> 2) & 32'h1F);
  endfunction

  function automatic instruction_t mem_word(word_t a);
    if (nop_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    c_addr.delete();
    c_data.delete();
    m_pc = 32'h0; m_miss_addr = '0; m_addr = '0; m_dpc = '0; m_inst = '0;
    m_miss = 0; m_req = 0; m_issue = 0; m_miss_cycles = 0;
    prev_req_obs = 0; req_rises = 0;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    bus.stall_in = 0; bus.rob_jump_in = 0; bus.rob_pc_in = '0;
    bus.mc_ready_in = 0; bus.mc_data_in = '0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive at the negedge, advance the model, compare 1 time unit after the posedge.
  task automatic step(input bit stall, input bit jump, input word_t jpc);
    bit           ready;
    instruction_t rdata;
    int           idx;
    ready = m_miss && (m_miss_cycles + 1 >= mc_latency);
    rdata = ready ? mem_word(m_miss_addr) : instruction_t'($urandom);
    bus.stall_in    = stall;
    bus.rob_jump_in = jump;
    bus.rob_pc_in   = jump ? jpc : word_t'($urandom);
    bus.mc_ready_in = ready;
    bus.mc_data_in  = rdata;

    m_issue = 0;
    if (m_miss) begin
      m_miss_cycles++;
      if (ready) begin
        idx = idx_of(m_miss_addr);
        c_addr[idx] = m_miss_addr;
        c_data[idx] = rdata;
        m_miss = 0;
        m_req = 0;
      end
      if (jump) m_pc = jpc;
    end else if (jump) begin
      m_pc = jpc;
    end else if (!stall) begin
      idx = idx_of(m_pc);
      if (c_addr.exists(idx) && c_addr[idx] == m_pc) begin
        m_issue = 1; m_inst = c_data[idx]; m_dpc = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_miss = 1; m_miss_cycles = 0; m_miss_addr = m_pc; m_req = 1; m_addr = m_pc;
      end
    end

    @(posedge clk);
    #1;
    checks += 5;
    if (bus.dec_issue_signal_out !== m_issue) begin
      failures++; $display("FAIL issue: got %b expected %b at %0t", bus.dec_issue_signal_out, m_issue, $time);
    end
    if (bus.dec_inst_out !== m_inst) begin
      failures++; $display("FAIL inst: got %h expected %h at %0t", bus.dec_inst_out, m_inst, $time);
    end
    if (bus.dec_pc_out !== m_dpc) begin
      failures++; $display("FAIL dec_pc: got %h expected %h at %0t", bus.dec_pc_out, m_dpc, $time);
    end
    if (bus.mc_req_out !== m_req) begin
      failures++; $display("FAIL mc_req: got %b expected %b at %0t", bus.mc_req_out, m_req, $time);
    end
    if (bus.mc_addr_out !== m_addr) begin
      failures++; $display("FAIL mc_addr: got %h expected %h at %0t", bus.mc_addr_out, m_addr, $time);
    end
    if (bus.mc_req_out === 1'b1 && !prev_req_obs) req_rises++;
    prev_req_obs = (bus.mc_req_out === 1'b1);
    @(negedge clk);
  endtask

  task automatic run_to_issue(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step(0, 0, '0);
      if (bus.dec_issue_signal_out === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got no issue expected one within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    nop_mode = 1; mc_latency = 3;
    assert_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (bus.mc_req_out !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", bus.mc_req_out); end
    if (bus.mc_addr_out !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", bus.mc_addr_out); end
    if (bus.dec_issue_signal_out !== 1'b0) begin failures++; $display("FAIL rst_issue: got %b expected 0", bus.dec_issue_signal_out); end
    if (bus.dec_inst_out !== 32'h0) begin failures++; $display("FAIL rst_inst: got %h expected 0", bus.dec_inst_out); end
    if (bus.dec_pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h expected 0", bus.dec_pc_out); end
    release_reset();
    step(0, 0, '0);
    checks += 2;
    if (bus.mc_req_out !== 1'b1) begin failures++; $display("FAIL first_req: got %b expected 1", bus.mc_req_out); end
    if (bus.mc_addr_out !== 32'h0) begin failures++; $display("FAIL first_addr: got %h expected 0", bus.mc_addr_out); end
  endtask

  task automatic test_cold_fetch();
    word_t pcs[$];
    for (int i = 0; i < 60 && pcs.size() < 4; i++) begin
      step(0, 0, '0);
      if (bus.dec_issue_signal_out === 1'b1) begin
        pcs.push_back(bus.dec_pc_out);
        checks++;
        if (bus.dec_inst_out !== 32'h13) begin failures++; $display("FAIL cold_inst: got %h expected 00000013", bus.dec_inst_out); end
      end
    end
    checks++;
    if (pcs.size() != 4) begin
      failures++; $display("FAIL cold_count: got %0d expected 4", pcs.size());
    end else begin
      foreach (pcs[i]) begin
        checks++;
        if (pcs[i] !== word_t'(4 * i)) begin failures++; $display("FAIL cold_order: got %h expected %h", pcs[i], 4 * i); end
      end
    end
    step(0, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0);
      checks += 3;
      if (bus.dec_issue_signal_out !== 1'b1) begin failures++; $display("FAIL warm_issue: got %b expected 1", bus.dec_issue_signal_out); end
      if (bus.dec_pc_out !== word_t'(4 * i)) begin failures++; $display("FAIL warm_pc: got %h expected %h", bus.dec_pc_out, 4 * i); end
      if (bus.mc_req_out !== 1'b0) begin failures++; $display("FAIL warm_req: got %b expected 0", bus.mc_req_out); end
    end
  endtask

  task automatic test_stall();
    step(0, 1, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, '0);
      checks++;
      if (bus.dec_issue_signal_out !== 1'b0) begin failures++; $display("FAIL stall_issue: got %b expected 0", bus.dec_issue_signal_out); end
    end
    step(0, 0, '0);
    checks += 2;
    if (bus.dec_issue_signal_out !== 1'b1) begin failures++; $display("FAIL stall_release: got %b expected 1", bus.dec_issue_signal_out); end
    if (bus.dec_pc_out !== 32'h8) begin failures++; $display("FAIL stall_pc: got %h expected 00000008", bus.dec_pc_out); end
  endtask

  task automatic test_redirect_during_miss();
    bit got;
    nop_mode = 0; mc_latency = 4;
    step(0, 1, 32'h40);
    step(0, 0, '0);
    step(0, 0, '0);
    step(0, 1, 32'h0);
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (bus.mc_req_out === 1'b1) begin
        checks++;
        if (bus.mc_addr_out !== 32'h40) begin failures++; $display("FAIL miss_addr_hold: got %h expected 00000040", bus.mc_addr_out); end
      end
      step(0, 0, '0);
      got = (bus.dec_issue_signal_out === 1'b1);
    end
    checks += 3;
    if (!got) begin failures++; $display("FAIL redirect_issue: got none expected issue of 00000000"); end
    if (bus.dec_pc_out !== 32'h0) begin failures++; $display("FAIL redirect_pc: got %h expected 00000000", bus.dec_pc_out); end
    if (bus.dec_inst_out !== 32'h13) begin failures++; $display("FAIL redirect_inst: got %h expected 00000013", bus.dec_inst_out); end
    step(0, 1, 32'h40);
    step(0, 0, '0);
    checks += 3;
    if (bus.dec_issue_signal_out !== 1'b1) begin failures++; $display("FAIL fill_kept: got %b expected 1", bus.dec_issue_signal_out); end
    if (bus.dec_inst_out !== mem_word(32'h40)) begin failures++; $display("FAIL fill_data: got %h expected %h", bus.dec_inst_out, mem_word(32'h40)); end
    if (bus.mc_req_out !== 1'b0) begin failures++; $display("FAIL fill_no_req: got %b expected 0", bus.mc_req_out); end
  endtask

  task automatic test_jump_on_hit();
    bit got;
    step(0, 1, 32'h4);
    step(0, 1, 32'h100);
    checks++;
    if (bus.dec_issue_signal_out !== 1'b0) begin failures++; $display("FAIL jump_hit_issue: got %b expected 0", bus.dec_issue_signal_out); end
    run_to_issue(20, got);
    checks++;
    if (got && bus.dec_pc_out !== 32'h100) begin failures++; $display("FAIL jump_target: got %h expected 00000100", bus.dec_pc_out); end
  endtask

  task automatic test_conflict_eviction();
    bit got;
    word_t targets[3] = '{32'h0, 32'h80, 32'h0};
    nop_mode = 0; mc_latency = 2;
    assert_reset();
    release_reset();
    foreach (targets[i]) begin
      if (i != 0) step(0, 1, targets[i]);
      run_to_issue(20, got);
      checks++;
      if (got && bus.dec_pc_out !== targets[i]) begin failures++; $display("FAIL evict_pc: got %h expected %h", bus.dec_pc_out, targets[i]); end
    end
    checks += 2;
    if (bus.dec_inst_out !== mem_word(32'h0)) begin failures++; $display("FAIL evict_inst: got %h expected %h", bus.dec_inst_out, mem_word(32'h0)); end
    if (req_rises != 3) begin failures++; $display("FAIL evict_misses: got %0d expected 3", req_rises); end
  endtask

  task automatic test_pc_wrap();
    bit got;
    step(0, 1, 32'hFFFF_FFFC);
    run_to_issue(20, got);
    checks++;
    if (got && bus.dec_pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_last: got %h expected fffffffc", bus.dec_pc_out); end
    run_to_issue(20, got);
    checks++;
    if (got && bus.dec_pc_out !== 32'h0) begin failures++; $display("FAIL wrap_zero: got %h expected 00000000", bus.dec_pc_out); end
  endtask

  task automatic test_reset_mid_miss();
    bit got;
    mc_latency = 5;
    step(0, 1, 32'h200);
    step(0, 0, '0);
    step(0, 0, '0);
    #2;
    assert_reset();
    checks += 3;
    if (bus.mc_req_out !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b expected 0", bus.mc_req_out); end
    if (bus.mc_addr_out !== 32'h0) begin failures++; $display("FAIL midrst_addr: got %h expected 0", bus.mc_addr_out); end
    if (bus.dec_pc_out !== 32'h0) begin failures++; $display("FAIL midrst_pc: got %h expected 0", bus.dec_pc_out); end
    release_reset();
    mc_latency = 2;
    run_to_issue(20, got);
    checks++;
    if (got && bus.dec_inst_out !== mem_word(32'h0)) begin failures++; $display("FAIL midrst_refetch: got %h expected %h", bus.dec_inst_out, mem_word(32'h0)); end
  endtask

  task automatic test_random();
    bit    stall, jump;
    word_t jpc;
    for (int i = 0; i < 1500; i++) begin
      if (!m_miss && ($urandom % 40) == 0) mc_latency = int'($urandom_range(1, 5));
      stall = ($urandom % 4) == 0;
      jump  = ($urandom % 12) == 0;
      jpc   = (($urandom % 6) == 0) ? (word_t'($urandom) & ~word_t'(3)) : word_t'($urandom_range(0, 127) << 2);
      step(stall, jump, jpc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_fetch();
    test_stall();
    test_redirect_during_miss();
    test_jump_on_hit();
    test_conflict_eviction();
    test_pc_wrap();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Front-end fetch unit of the Tomasulo core. Holds the architectural fetch PC and looks instructions up in a direct-mapped instruction cache. On a miss it refills the cache from the memory controller. It then drives one instruction per cycle into the decoder's issue interface (issue signal, 32-bit instruction, PC). It also accepts stall back-pressure from the dispatch side and PC redirects from the reorder buffer.

## Interface
- `ICACHE_INDEX_WIDTH`, 5, log2 of the number of cache entries. Each entry holds one 32-bit word.
- `RESET_PC`, 32'h0, fetch PC after reset.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-low. Asserting `rst` low clears all state immediately.
- `stall_in` input 1: RS, LSB or ROB full; no issue may occur in a cycle where this is high.
- `rob_jump_in` input 1: misprediction or jump redirect pulse from the ROB.
- `rob_pc_in` input 32: redirect target, valid when `rob_jump_in` is high.
- `mc_req_out` output 1: instruction word read request to the memory controller.
- `mc_addr_out` output 32: word-aligned request address.
- `mc_ready_in` input 1: one-cycle pulse; `mc_data_in` is valid in that cycle.
- `mc_data_in` input 32: returned instruction word.
- `dec_issue_signal_out` output 1: instruction valid for the decoder this cycle.
- `dec_inst_out` output 32: instruction word.
- `dec_pc_out` output 32: PC of `dec_inst_out`.

## Operation
- State:
  - `pc` (32 bit).
  - FSM state, one of IDLE or MISS.
  - `miss_addr` (32 bit).
  - Cache arrays: `valid[N]`, `tag[N]` of width 30-ICACHE_INDEX_WIDTH, and `data[N]` of width 32, where N = 2^ICACHE_INDEX_WIDTH.
- Address split:
  - index = `pc[ICACHE_INDEX_WIDTH+1:2]`
  - tag = `pc[31:ICACHE_INDEX_WIDTH+2]`
  - `pc[1:0]` is ignored (always 0).
- hit = `valid[index]` && `tag[index]` == tag of `pc`.
- IDLE, priority order each cycle:
  1. `rob_jump_in`: `pc` <= `rob_pc_in`; no issue.
  2. `stall_in`: no change; no issue.
  3. hit: issue `data[index]` with `pc`; `pc` <= `pc`+4. Wraps mod 2^32.
  4. miss: `miss_addr` <= `pc`; go to MISS.
- MISS:
  - `mc_req_out` is 1 and `mc_addr_out` = `miss_addr`, held constant until `mc_ready_in`.
  - On `mc_ready_in`, write `valid`/`tag`/`data` at `miss_addr`'s index, overwriting any previous entry, then return to IDLE.
  - `rob_jump_in` in MISS updates `pc` only. The outstanding request still completes and its fill is still written, since it is correct for `miss_addr`.
  - If `rob_jump_in` and `mc_ready_in` coincide, both take effect.
  - No issue ever occurs in MISS.
- Cache is never invalidated except by reset. Self-modifying code is unsupported.

## Timing
- Reset values:
  - `pc` = RESET_PC; state IDLE; all `valid` = 0.
  - `mc_req_out` = 0, `mc_addr_out` = 0.
  - `dec_issue_signal_out` = 0, `dec_inst_out` = 0, `dec_pc_out` = 0.
- Decoder outputs are registered. An issue decided in cycle t appears on `dec_*` during cycle t+1 only, with `dec_issue_signal_out` high for exactly one cycle per instruction.
- When not issuing, `dec_issue_signal_out` = 0 and `dec_inst_out`/`dec_pc_out` hold their last values.
- Hit throughput: one instruction per cycle while `stall_in` = 0.
- `stall_in` and `rob_jump_in` are sampled in cycle t and suppress the issue decided in cycle t. An instruction already on `dec_*` in cycle t is not retracted.
- Miss latency:
  - miss detected in cycle t.
  - `mc_req_out` high from t+1.
  - `mc_ready_in` arrives at t+k.
  - back in IDLE at t+k+1, where the hit is evaluated.
  - `dec_issue_signal_out` at t+k+2 at the earliest.
- `mc_req_out` drops in the cycle after `mc_ready_in`. A new request cannot start before t+k+2.
- After a redirect in cycle t, the first issue from the target appears no earlier than t+2.
- Reset mid-MISS: request abandoned immediately. The memory controller must tolerate a dropped request, since it is reset by the same `rst`.

## Structure
- Shared header supplies:
  - `WORD_RANGE`, `INSTRUCTION_RANGE`
  - `ZERO_WORD`, `TRUE`, `FALSE`
  - new constants `ICACHE_INDEX_RANGE` and `ICACHE_TAG_RANGE`, derived from the default `ICACHE_INDEX_WIDTH`
- FSM state encodings `FET_IDLE` / `FET_MISS` are local to this block.
- One sub-module: `instruction_cache`, containing the arrays, the hit logic, and a synchronous fill write port. `instruction_fetcher` contains the FSM, `pc` and the output registers.

## Test plan
- Reset with RESET_PC=0 -> all outputs 0, `mc_req_out` high 1 cycle after the first free cycle, `mc_addr_out` = 0x0.
- Cold fetch of 0x0..0xC:
  - memory returns 0x00000013 (nop) for each word with k=3.
  - Each instruction issues once, PCs 0,4,8,C in order.
  - Re-fetch after redirect to 0x0 issues 4 consecutive cycles with no `mc_req_out`.
- Stall on a warm cache at pc=0x8: hold `stall_in`=1 for 5 cycles -> no issue, `pc` stays 0x8. On release, 0x8 issues in the cycle after.
- Redirect during MISS:
  - miss at 0x40, `rob_jump_in` to 0x0 (cached) two cycles later.
  - `mc_addr_out` stays 0x40 until ready.
  - Entry for 0x40 is filled, then 0x0 issues. No instruction from 0x40 issues.
- Simultaneous redirect and hit: `rob_jump_in`=1 with target 0x100 while pc=0x4 hits -> no issue of 0x4, next issued PC is 0x100.
- Conflict eviction with index width 5:
  - fetch 0x0, then redirect to 0x80 (same index), then back to 0x0.
  - Three misses in total; 0x0 is refetched from memory.
